// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex: write side, read side, level flags and error flags.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en, err_clr,
        input  dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, err_clr,
        output dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with level flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full, empty, rd_acc, wr_acc;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.err_clr ? 1'b0 : overflow_q;
        underflow_d = bus.err_clr ? 1'b0 : underflow_q;
        if (wr_acc) w_ptr_d = ptr_inc(w_ptr_q);
        if (rd_acc) r_ptr_d = ptr_inc(r_ptr_q);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error in the clearing cycle takes precedence over the clear.
        if (bus.wr_en && !wr_acc) overflow_d  = 1'b1;
        if (bus.rd_en && !rd_acc) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[w_ptr_q] <= bus.din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.dout       = empty ? '0 : mem_q[r_ptr_q];
    assign bus.dout_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;

    // Nonblocking sample of the old entry makes a full-FIFO read+write return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (rd_acc) dout_q <= mem_q[r_ptr_q];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a depth-16 instance for the main sequences and a depth-5 one for wraps.
module tb_sync_fifo_flex;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) a_if();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5))  b_if();

    sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_d;
    logic [7:0] wseq, rseq;

    initial begin
        rst_n = 1'b1;
        a_if.wr_en = 0; a_if.rd_en = 0; a_if.err_clr = 0; a_if.din = '0;
        b_if.wr_en = 0; b_if.rd_en = 0; b_if.err_clr = 0; b_if.din = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_empty", a_if.empty, 1);
        chk("rst_full", a_if.full, 0);
        chk("rst_count", a_if.count, 0);
        chk("rst_af", a_if.almost_full, 0);
        chk("rst_ae", a_if.almost_empty, 1);
        chk("rst_dout", a_if.dout, 0);
        chk("rst_dval", a_if.dout_valid, 0);
        chk("rst_ovf", a_if.overflow, 0);
        chk("rst_udf", a_if.underflow, 0);
        #10 rst_n = 1'b1;

        // Fill 16 entries.
        for (int i = 1; i <= 16; i++) begin
            a_if.wr_en = 1; a_if.din = 8'(i);
            tick();
            chk("fill_count", a_if.count, i);
            chk("fill_af", a_if.almost_full, (i >= 14));
            chk("fill_ae", a_if.almost_empty, (i <= 2));
        end
        a_if.wr_en = 0;
        chk("full", a_if.full, 1);
        chk("full_ovf", a_if.overflow, 0);

        // Full with simultaneous read and write.
        a_if.wr_en = 1; a_if.rd_en = 1; a_if.din = 8'hAA;
`ifdef SYNC_FIFO_FWFT_EN
        chk("rw_full_dout", a_if.dout, 8'h01);
`endif
        tick();
`ifndef SYNC_FIFO_FWFT_EN
        chk("rw_full_dout", a_if.dout, 8'h01);
        chk("rw_full_dval", a_if.dout_valid, 1);
`endif
        chk("rw_full_count", a_if.count, 16);
        chk("rw_full_ovf", a_if.overflow, 0);

        a_if.rd_en = 0; a_if.din = 8'hBB;
        tick();
        chk("ovf_set", a_if.overflow, 1);
        chk("ovf_count", a_if.count, 16);
        a_if.wr_en = 0; a_if.err_clr = 1;
        tick();
        chk("ovf_clr", a_if.overflow, 0);
        a_if.err_clr = 0;

        // Drain: 0x02..0x10 then 0xAA.
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 15) ? 8'(k + 2) : 8'hAA;
            a_if.rd_en = 1;
`ifdef SYNC_FIFO_FWFT_EN
            chk("drain_dout", a_if.dout, exp_d);
            chk("drain_dval", a_if.dout_valid, 1);
            tick();
`else
            tick();
            chk("drain_dout", a_if.dout, exp_d);
            chk("drain_dval", a_if.dout_valid, 1);
`endif
        end
        chk("drain_empty", a_if.empty, 1);
        chk("drain_count", a_if.count, 0);

        // Empty with simultaneous read and write: read rejected.
        a_if.wr_en = 1; a_if.rd_en = 1; a_if.din = 8'h55;
        tick();
        chk("udf_set", a_if.underflow, 1);
        chk("udf_count", a_if.count, 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_dout", a_if.dout, 8'h55);
        chk("fwft_dval", a_if.dout_valid, 1);
`else
        chk("udf_dval", a_if.dout_valid, 0);
`endif
        a_if.wr_en = 0;
        tick();
`ifndef SYNC_FIFO_FWFT_EN
        chk("after_udf_dout", a_if.dout, 8'h55);
        chk("after_udf_dval", a_if.dout_valid, 1);
`else
        chk("fwft_pop_dval", a_if.dout_valid, 0);
        chk("fwft_pop_dout", a_if.dout, 0);
`endif
        chk("after_udf_empty", a_if.empty, 1);

        // Clear collides with a new underflow: set wins.
        a_if.err_clr = 1;
        tick();
        chk("set_wins", a_if.underflow, 1);
        a_if.rd_en = 0;
        tick();
        chk("udf_clr", a_if.underflow, 0);
        a_if.err_clr = 0;

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 7; i++) begin
            a_if.wr_en = 1; a_if.din = 8'(8'h70 + i);
            tick();
        end
        a_if.wr_en = 0;
        chk("burst_count", a_if.count, 7);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", a_if.count, 0);
        chk("mid_rst_empty", a_if.empty, 1);
        chk("mid_rst_dout", a_if.dout, 0);
        chk("mid_rst_dval", a_if.dout_valid, 0);
        rst_n = 1'b1;
        a_if.wr_en = 1; a_if.din = 8'h99;
        tick();
        a_if.wr_en = 0; a_if.rd_en = 1;
`ifdef SYNC_FIFO_FWFT_EN
        chk("post_rst_dout", a_if.dout, 8'h99);
        tick();
`else
        tick();
        chk("post_rst_dout", a_if.dout, 8'h99);
`endif
        a_if.rd_en = 0;
        tick();
        chk("post_rst_empty", a_if.empty, 1);

        // Depth-5 instance: 23 pushes with pointer wraps.
        wseq = 8'h20; rseq = 8'h20;
        for (int i = 0; i < 5; i++) begin
            b_if.wr_en = 1; b_if.din = wseq; wseq++;
            tick();
        end
        chk("d5_full", b_if.full, 1);
        chk("d5_count", b_if.count, 5);
        for (int i = 0; i < 18; i++) begin
            b_if.wr_en = 1; b_if.rd_en = 1; b_if.din = wseq; wseq++;
`ifdef SYNC_FIFO_FWFT_EN
            chk("d5_rw_dout", b_if.dout, rseq);
            tick();
`else
            tick();
            chk("d5_rw_dout", b_if.dout, rseq);
`endif
            rseq++;
            chk("d5_rw_count", b_if.count, 5);
        end
        b_if.wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            b_if.rd_en = 1;
`ifdef SYNC_FIFO_FWFT_EN
            chk("d5_drain_dout", b_if.dout, rseq);
            tick();
`else
            tick();
            chk("d5_drain_dout", b_if.dout, rseq);
`endif
            rseq++;
            chk("d5_drain_count", b_if.count, 4 - i);
        end
        b_if.rd_en = 0;
        tick();
        chk("d5_empty", b_if.empty, 1);
        chk("d5_ovf", b_if.overflow, 0);
        chk("d5_udf", b_if.underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock FIFO for any depth (not only powers of two), with a fill-level count, programmable almost-full/almost-empty flags, a registered read-data valid strobe, and sticky overflow/underflow error flags. It is the general-purpose buffering block between producer and consumer stages in the same clock domain. An optional first-word-fall-through read mode is available at compile time.

Parameters:
DATA_WIDTH, 8, width of din/dout in bits (>=1)
FIFO_DEPTH, 16, number of storage entries (>=2; need not be a power of two)
AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..FIFO_DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..FIFO_DEPTH-1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request
dout  output  DATA_WIDTH  read data
dout_valid  output  1  dout carries a newly popped word (standard mode)
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CNT_W  current occupancy; CNT_W = $clog2(FIFO_DEPTH+1)
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, rst_n low): w_ptr=0, r_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. So empty=1, full=0, almost_empty=1, and almost_full=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal AF_LEVEL. Memory contents are not reset. Reset mid-operation discards all data immediately.
- Pointer width: $clog2(FIFO_DEPTH), minimum 1. Pointers wrap explicitly: a pointer at FIFO_DEPTH-1 goes to 0. No masking arithmetic.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- A read on an empty FIFO is never accepted, even with a simultaneous write. The written word becomes readable the next cycle.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur. count never exceeds FIFO_DEPTH and never goes below 0.
- full, empty, almost_full, almost_empty: combinational from the registered count. They update in the cycle after the causing edge.
- Standard read: on rd_acc, dout <= mem[r_ptr] at the clock edge and dout_valid=1 for that following cycle. Otherwise dout_valid=0 and dout holds its last value. Latency is one cycle from an accepted rd_en to data.
- Write-during-read at the same address (full with simultaneous read and write): the read returns the old entry; the write lands after it.
- overflow: set on the edge where wr_en && !wr_acc. underflow: set on the edge where rd_en && !rd_acc.
- err_clr clears both flags on its edge. If a new error occurs in the same cycle as err_clr, set wins.
- Error flags never affect data or pointers.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (FWFT mode): dout combinationally shows mem[r_ptr] whenever !empty, and is 0 when empty. rd_en acknowledges (pops) the current word. dout_valid = !empty. Acceptance rules, count and flags are unchanged. A word written into an empty FIFO appears on dout one cycle after the write edge.
- Not defined: the standard registered read described above.

Test Plan:
- Reset, then write 0x01..0x10 on 16 consecutive cycles (DEPTH=16) -> full=1, count=16, almost_full set from count=14, no overflow. Then 16 reads -> dout 0x01..0x10 in order, each with dout_valid one cycle after rd_en; empty=1 at the end.
- Full FIFO, one cycle with wr_en=rd_en=1 and din=0xAA -> oldest word read, 0xAA accepted, count stays 16, overflow=0. The next wr_en alone -> rejected, overflow=1. Then err_clr pulse -> overflow=0.
- Empty FIFO, rd_en=1 with wr_en=1 and din=0x55 -> read rejected, underflow=1, count=1. Next-cycle read returns 0x55.
- FIFO_DEPTH=5, 23 pushes and pops interleaved to force multiple pointer wraps at 4->0 -> data order preserved, count stays within 0..5.
- Assert rst_n low mid-burst with count=7 -> all outputs take reset values asynchronously. After release, first read data equals the first post-reset write.
- SYNC_FIFO_FWFT_EN defined: write 0x3C into empty FIFO -> dout=0x3C and dout_valid=1 on the next cycle with no rd_en. rd_en pops it -> empty=1, dout_valid=0.
